// File: rtl/btn_pkg.sv
// Shared types and constants for the debounced push-button input block.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } btn_state_t;

  localparam int MS_PER_S = 1000;

  // Bits needed to count 0 .. n_states-1, never less than one bit.
  function automatic int cnt_width(input int n_states);
    return (n_states > 1) ? $clog2(n_states) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchronizer, tick-based debounce counter and a
// press/hold state machine that emits press, release and long-press pulses.
module btn_channel
  import btn_pkg::*;
#(
  parameter logic BTN_ACTIVE    = 1'b1,
  parameter int   DEBOUNCE_MS   = 10,
  parameter int   LONG_PRESS_MS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick_i,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DBW = cnt_width(DEBOUNCE_MS + 1);
  localparam int HW  = cnt_width(LONG_PRESS_MS + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_PRESS_MS - 1);

  logic           ff1_q, ff2_q;
  logic           sync;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           long_q, long_d;
  btn_state_t     state_q, state_d;

  assign sync = (ff2_q == BTN_ACTIVE);

  always_comb begin
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    state_d    = state_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    // A new level must persist across DEBOUNCE_MS ticks; any bounce restarts it.
    if (sync == level_q) begin
      db_cnt_d = '0;
    end else if (ms_tick_i) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = sync;
        db_cnt_d  = '0;
        press_d   = sync;
        release_d = ~sync;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end

    case (state_q)
      RELEASED: begin
        if (press_d) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (release_d) begin
          state_d = RELEASED;
        end else if (ms_tick_i) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = HELD;
            long_d  = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      HELD: begin
        if (release_d) state_d = RELEASED;
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q      <= ~BTN_ACTIVE;
      ff2_q      <= ~BTN_ACTIVE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      state_q    <= RELEASED;
    end else begin
      ff1_q      <= btn_raw_i;
      ff2_q      <= ff1_q;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      state_q    <= state_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/btn_input.sv
// Debounced push-button block: free-running 1 ms prescaler shared by
// BTN_NUM independent button channels.
module btn_input
  import btn_pkg::*;
#(
  parameter int   CLOCK_XTAL    = 27000000,
  parameter int   BTN_NUM       = 2,
  parameter logic BTN_ACTIVE    = 1'b1,
  parameter int   DEBOUNCE_MS   = 10,
  parameter int   LONG_PRESS_MS = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BTN_NUM-1:0] btn_raw,
  output logic [BTN_NUM-1:0] btn_level,
  output logic [BTN_NUM-1:0] btn_press,
  output logic [BTN_NUM-1:0] btn_release,
  output logic [BTN_NUM-1:0] btn_long
);

  localparam int DIV = CLOCK_XTAL / MS_PER_S;
  localparam int PW  = cnt_width(DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  if (CLOCK_XTAL < MS_PER_S) begin : g_err_clock
    $error("btn_input: CLOCK_XTAL must be >= 1000");
  end
  if (DEBOUNCE_MS < 1) begin : g_err_debounce
    $error("btn_input: DEBOUNCE_MS must be >= 1");
  end
  if (LONG_PRESS_MS <= DEBOUNCE_MS) begin : g_err_long
    $error("btn_input: LONG_PRESS_MS must exceed DEBOUNCE_MS");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic          ms_tick;

  assign ms_tick = (presc_q == PS_LAST);
  assign presc_d = ms_tick ? '0 : presc_q + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  genvar gi;
  for (gi = 0; gi < BTN_NUM; gi++) begin : g_chan
    btn_channel #(
      .BTN_ACTIVE   (BTN_ACTIVE),
      .DEBOUNCE_MS  (DEBOUNCE_MS),
      .LONG_PRESS_MS(LONG_PRESS_MS)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .ms_tick_i(ms_tick),
      .btn_raw_i(btn_raw[gi]),
      .level_o  (btn_level[gi]),
      .press_o  (btn_press[gi]),
      .release_o(btn_release[gi]),
      .long_o   (btn_long[gi])
    );
  end

endmodule

// File: tb/tb_btn_input.sv
// Scoreboard bench: an event-time reference model predicts every pulse and
// the debounced level; a monitor compares them against two DUT instances.
module tb_btn_input;

  localparam int CLK_XTAL = 10000;
  localparam int DIV      = 10;
  localparam int DEB      = 4;
  localparam int LONG     = 20;
  localparam int NCH      = 4;  // ch 0,1: active-high DUT; ch 2,3: active-low DUT

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] raw_a, raw_b;
  logic [1:0] lvl_a, prs_a, rel_a, lng_a;
  logic [1:0] lvl_b, prs_b, rel_b, lng_b;

  wire [3:0] raw_all = {raw_b, raw_a};
  wire [3:0] lvl_all = {lvl_b, lvl_a};
  wire [3:0] prs_all = {prs_b, prs_a};
  wire [3:0] rel_all = {rel_b, rel_a};
  wire [3:0] lng_all = {lng_b, lng_a};

  always #5 clk = ~clk;

  btn_input #(
    .CLOCK_XTAL(CLK_XTAL), .BTN_NUM(2), .BTN_ACTIVE(1'b1),
    .DEBOUNCE_MS(DEB), .LONG_PRESS_MS(LONG)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_a), .btn_level(lvl_a),
    .btn_press(prs_a), .btn_release(rel_a), .btn_long(lng_a)
  );

  btn_input #(
    .CLOCK_XTAL(CLK_XTAL), .BTN_NUM(2), .BTN_ACTIVE(1'b0),
    .DEBOUNCE_MS(DEB), .LONG_PRESS_MS(LONG)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_b), .btn_level(lvl_b),
    .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b)
  );

  typedef struct {
    int edge_n;
    int ch;
    int kind;   // 0 press, 1 release, 2 long
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cur_edge = 0;   // clock edges since reset was released

  // Reference model state
  bit m_level[NCH];
  bit m_h1[NCH], m_h2[NCH];
  int m_run[NCH];
  int m_press_at[NCH];
  bit m_long_done[NCH];

  // Monitor statistics, indexed [kind][channel]
  int cnt[3][NCH];
  int at[3][NCH];

  function automatic bit active_lvl(input int c);
    return (c < 2) ? 1'b1 : 1'b0;
  endfunction

  // Number of millisecond ticks on edges a..b (a tick happens on every DIV-th edge).
  function automatic int ticks_in(input int a, input int b);
    return b / DIV - (a - 1) / DIV;
  endfunction

  // Reference model
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cur_edge = 0;
        for (int c = 0; c < NCH; c++) begin
          m_level[c]     = 1'b0;
          m_h1[c]        = ~active_lvl(c);
          m_h2[c]        = ~active_lvl(c);
          m_run[c]       = -1;
          m_press_at[c]  = 0;
          m_long_done[c] = 1'b1;
        end
        exp_q.delete();
      end else begin
        bit tick;
        cur_edge++;
        tick = (cur_edge % DIV == 0);
        for (int c = 0; c < NCH; c++) begin
          bit s;
          s = (m_h2[c] == active_lvl(c));
          m_h2[c] = m_h1[c];
          m_h1[c] = raw_all[c];
          if (s == m_level[c]) begin
            m_run[c] = -1;
          end else begin
            if (m_run[c] < 0) m_run[c] = cur_edge;
            if (tick && ticks_in(m_run[c], cur_edge) == DEB) begin
              m_level[c] = s;
              m_run[c]   = -1;
              exp_q.push_back('{edge_n: cur_edge, ch: c, kind: (s ? 0 : 1)});
              if (s) begin
                m_press_at[c]  = cur_edge;
                m_long_done[c] = 1'b0;
              end else begin
                m_long_done[c] = 1'b1;
              end
            end
          end
          if (m_level[c] && !m_long_done[c] && tick &&
              ticks_in(m_press_at[c] + 1, cur_edge) == LONG) begin
            exp_q.push_back('{edge_n: cur_edge, ch: c, kind: 2});
            m_long_done[c] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    string kname[3];
    kname[0] = "press";
    kname[1] = "release";
    kname[2] = "long";
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        n_checks++;
        if ((lvl_all | prs_all | rel_all | lng_all) != 4'b0) begin
          n_fail++;
          $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b lng=%b, expected all 0",
                   lvl_all, prs_all, rel_all, lng_all);
        end
      end else begin
        logic [3:0] m_vec;
        for (int c = 0; c < NCH; c++) begin
          for (int k = 0; k < 3; k++) begin
            logic p;
            p = (k == 0) ? prs_all[c] : (k == 1) ? rel_all[c] : lng_all[c];
            if (p) begin
              cnt[k][c]++;
              at[k][c] = cur_edge;
              $display("[%0t] edge %0d ch%0d %s", $time, cur_edge, c, kname[k]);
              n_checks++;
              if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got ch%0d %s at edge %0d, expected none",
                         c, kname[k], cur_edge);
              end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.edge_n != cur_edge || e.ch != c || e.kind != k) begin
                  n_fail++;
                  $display("FAIL event_match: got ch%0d %s at edge %0d, expected ch%0d %s at edge %0d",
                           c, kname[k], cur_edge, e.ch, kname[e.kind], e.edge_n);
                end
              end
            end
          end
        end
        while (exp_q.size() > 0 && exp_q[0].edge_n <= cur_edge) begin
          ev_t e;
          e = exp_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missing_event: got nothing at edge %0d, expected ch%0d %s",
                   cur_edge, e.ch, kname[e.kind]);
        end
        for (int c = 0; c < NCH; c++) m_vec[c] = m_level[c];
        n_checks++;
        if (lvl_all != m_vec) begin
          n_fail++;
          $display("FAIL level: got %b at edge %0d, expected %b", lvl_all, cur_edge, m_vec);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Stimulus
  initial begin
    int k, bp, br, bl, bp1, br1, bl1;
    raw_a = 2'b00;
    raw_b = 2'b11;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cyc(5);
    rst_n = 1'b1;
    cyc(20);

    // Clean press and release on channel 0
    bp = cnt[0][0]; br = cnt[1][0]; bl = cnt[2][0];
    raw_a[0] = 1'b1; k = cur_edge;
    cyc(100);
    chk("s1_press_count", cnt[0][0] - bp, 1, 1);
    chk("s1_press_latency", at[0][0] - k, 33, 43);
    raw_a[0] = 1'b0; k = cur_edge;
    cyc(60);
    chk("s1_release_count", cnt[1][0] - br, 1, 1);
    chk("s1_release_latency", at[1][0] - k, 33, 43);
    chk("s1_no_long", cnt[2][0] - bl, 0, 0);

    // Bounce rejection
    bp = cnt[0][0]; br = cnt[1][0]; bl = cnt[2][0];
    for (int i = 0; i < 12; i++) begin
      raw_a[0] = ~raw_a[0];
      cyc(25);
    end
    raw_a[0] = 1'b0;
    cyc(60);
    chk("s2_no_press", cnt[0][0] - bp, 0, 0);
    chk("s2_no_release", cnt[1][0] - br, 0, 0);
    chk("s2_no_long", cnt[2][0] - bl, 0, 0);
    chk("s2_level_low", int'(lvl_all[0]), 0, 0);

    // Long press on channel 1
    bp = cnt[0][1]; br = cnt[1][1]; bl = cnt[2][1];
    raw_a[1] = 1'b1;
    cyc(400);
    raw_a[1] = 1'b0;
    cyc(60);
    chk("s3_press_count", cnt[0][1] - bp, 1, 1);
    chk("s3_long_count", cnt[2][1] - bl, 1, 1);
    chk("s3_long_delay", at[2][1] - at[0][1], 190, 210);
    chk("s3_release_count", cnt[1][1] - br, 1, 1);

    // Simultaneous channels
    bp = cnt[0][0]; bp1 = cnt[0][1];
    raw_a = 2'b11;
    cyc(60);
    chk("s4_press0_count", cnt[0][0] - bp, 1, 1);
    chk("s4_press1_count", cnt[0][1] - bp1, 1, 1);
    chk("s4_same_cycle", at[0][0] - at[0][1], 0, 0);
    raw_a = 2'b00;
    cyc(60);

    // Reset mid-press
    raw_a[0] = 1'b1;
    cyc(50);
    chk("s5_level_before_reset", int'(lvl_all[0]), 1, 1);
    bp = cnt[0][0]; br = cnt[1][0];
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(60);
    chk("s5_no_release", cnt[1][0] - br, 0, 0);
    chk("s5_repress_count", cnt[0][0] - bp, 1, 1);
    chk("s5_repress_latency", at[0][0], 33, 43);
    raw_a[0] = 1'b0;
    cyc(60);

    // Active-low instance, channel 2
    bp = cnt[0][2];
    chk("s6_idle_level", int'(lvl_all[2]), 0, 0);
    raw_b[0] = 1'b0; k = cur_edge;
    cyc(60);
    chk("s6_press_count", cnt[0][2] - bp, 1, 1);
    chk("s6_press_latency", at[0][2] - k, 33, 43);
    chk("s6_level_pressed", int'(lvl_all[2]), 1, 1);
    raw_b[0] = 1'b1;
    cyc(60);

    // Randomised pin activity on all four channels
    bl = cnt[2][0] + cnt[2][1] + cnt[2][2] + cnt[2][3];
    bp = cnt[0][0] + cnt[0][1] + cnt[0][2] + cnt[0][3];
    br1 = 0; bl1 = 0;
    repeat (150) begin
      int idx;
      cyc($urandom_range(1, 45));
      idx = $urandom_range(0, 3);
      if (idx < 2) raw_a[idx] = ~raw_a[idx];
      else         raw_b[idx - 2] = ~raw_b[idx - 2];
      if ($urandom_range(0, 9) == 0) begin
        cyc($urandom_range(200, 260));
      end
    end
    raw_a = 2'b00;
    raw_b = 2'b11;
    cyc(300);
    br1 = cnt[0][0] + cnt[0][1] + cnt[0][2] + cnt[0][3] - bp;
    bl1 = cnt[2][0] + cnt[2][1] + cnt[2][2] + cnt[2][3] - bl;
    $display("random phase: %0d presses, %0d long presses", br1, bl1);
    chk("final_levels_released", int'(lvl_all), 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_input.md
# btn_input

Debounced push-button input block for the Tang Nano 20K board: the input-side counterpart of the LED output path. Synchronizes raw button pins to `clk`, debounces them against a shared 1 ms tick, and reports a stable level plus single-cycle press, release and long-press events. It sits between the board button pins and the control logic that drives the LEDs.

## Interface
- `CLOCK_XTAL`, 27000000: input clock frequency in Hz; must be ≥1000.
- `BTN_NUM`, 2: number of buttons.
- `BTN_ACTIVE`, 1'b1: pin level that means "pressed".
- `DEBOUNCE_MS`, 10: ms a new level must hold before it is accepted; must be ≥1.
- `LONG_PRESS_MS`, 1000: ms of stable press before the long-press event; must be > `DEBOUNCE_MS`.
- `clk`  in  1  system clock. One clock only.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `btn_raw`  in  `BTN_NUM`  raw, asynchronous button pins.
- `btn_level`  out  `BTN_NUM`  debounced state; 1 = pressed, independent of `BTN_ACTIVE`.
- `btn_press`  out  `BTN_NUM`  one-cycle pulse when the debounced state goes to pressed.
- `btn_release`  out  `BTN_NUM`  one-cycle pulse when the debounced state goes to released.
- `btn_long`  out  `BTN_NUM`  one-cycle pulse, at most once per press, after `LONG_PRESS_MS` pressed.

## Operation
- Prescaler: counts 0 to `CLOCK_XTAL/1000 - 1` (integer division), then wraps. `ms_tick` is high for 1 cycle at the wrap. It is free-running and shared by all channels.
- Per channel, synchronizer: a 2-FF synchronizer on `btn_raw` is followed by normalization `sync = (ff2 == BTN_ACTIVE)`.
- Per channel, debounce counter `db_cnt`, width `$clog2(DEBOUNCE_MS+1)`:
  - `sync == btn_level`: `db_cnt <= 0`. Any bounce back clears the count.
  - `sync != btn_level` and `ms_tick`, with `db_cnt == DEBOUNCE_MS-1`: `btn_level <= sync`, `db_cnt <= 0`, and pulse `btn_press` or `btn_release` in the same cycle.
  - Otherwise, when `ms_tick`: `db_cnt++`.
- Per channel FSM, with states RELEASED, PRESSED, HELD:
  - RELEASED → PRESSED on accepted press. Clear `hold_cnt`.
  - PRESSED: `hold_cnt++` on `ms_tick`. When `hold_cnt == LONG_PRESS_MS-1` and `ms_tick`, go to HELD and pulse `btn_long`.
  - PRESSED or HELD → RELEASED on accepted release. `btn_release` fires from both states.
  - HELD: no further `btn_long` events and no counting.
- `hold_cnt` width is `$clog2(LONG_PRESS_MS+1)`. It never wraps, because it stops at HELD.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Elaboration check: `$error` if any parameter rule above is violated.

## Timing
- Reset (`rst_n` low, asynchronous):
  - All outputs are 0.
  - Synchronizer FFs are loaded with `~BTN_ACTIVE`.
  - Counters and prescaler are 0. FSM is RELEASED.
- Latency from pin change to event: 2 sync cycles, plus between `(DEBOUNCE_MS-1)` and `DEBOUNCE_MS` ms of tick alignment, plus 1 register cycle.
- `btn_level` changes in the same cycle as its press or release pulse.
- Long press fires `LONG_PRESS_MS` ticks after entering PRESSED, with ±1 tick of alignment.
- Pulses are exactly 1 cycle wide. No back-pressure and no handshake: consumers sample every cycle.
- Reset mid-press: all state is lost with no release pulse. A button still held after reset is re-debounced and produces a fresh `btn_press`.
- Release and press can never coincide on one channel; the counter allows at most one accepted change per `DEBOUNCE_MS`.

## Structure
- Package `btn_pkg` holds:
  - the `btn_state_t` enum: RELEASED, PRESSED, HELD;
  - the `MS_PER_S = 1000` constant;
  - a `div_ceil`/`clog2` helper for counter widths, if needed.
- Sub-module `btn_channel` contains the synchronizer, debounce counter, FSM and hold counter for one button. It takes `ms_tick` as an input.
- `btn_input` contains the prescaler and a generate loop of `BTN_NUM` × `btn_channel`.

## Test plan
All scenarios use bench parameters `CLOCK_XTAL=10000` (tick every 10 cycles), `DEBOUNCE_MS=4`, `LONG_PRESS_MS=20`, `BTN_NUM=2`, `BTN_ACTIVE=1`.
- **Clean press and release:** raise `btn_raw[0]`, hold for 100 cycles, then drop it. Expect:
  - `btn_press[0]` 1 cycle within 33–43 cycles after the rise, with `btn_level[0]=1` from that cycle;
  - `btn_release[0]` 1 cycle within 33–43 cycles after the drop;
  - `btn_long[0]` never asserted.
- **Bounce rejection:** toggle `btn_raw[0]` every 25 cycles for 300 cycles, then hold it low. Expect no press, release or long pulse and `btn_level[0]=0` throughout.
- **Long press:** hold `btn_raw[1]` high for 400 cycles. Expect:
  - `btn_press[1]`;
  - exactly one `btn_long[1]`, 190–210 cycles after the press;
  - `btn_release[1]` after the drop.
- **Simultaneous channels:** raise `btn_raw[0]` and `btn_raw[1]` in the same cycle. Expect `btn_press` = 2'b11 in the same single cycle.
- **Reset mid-press:** hold the button until `btn_level=1`, then pulse `rst_n` low for 3 cycles while the pin is still high. Expect:
  - all outputs 0 during reset, with no release pulse;
  - a new `btn_press` within 33–43 cycles after `rst_n` rises.
- **Active-low variant:** set `BTN_ACTIVE=0`, idle the pin high, then drive it low. Expect `btn_level=0` while idle, then `btn_press` followed by `btn_level=1`.
